// File: rtl/coef_buf_rd.sv
// coef_buf_rd: read-side controller for the 64x512 two-port coefficient buffer.
// It takes a block request (base, length) and issues reads on the buffer B
// port, which has a one-cycle read latency. The returned words go to the
// consumer over a valid/ready handshake. A 2-entry skid FIFO holds the
// in-flight read data, so backpressure never drops or repeats a word.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            request pulse, accepted only while busy_o==0
//   base_i, len_i      first word address / word count (0..512), sampled with start_i
//   busy_o             request in progress
//   done_o             one-cycle pulse, request complete
//   err_o              one-cycle pulse, request rejected (address range overflow)
//   b_re, b_addr       buffer read enable / address
//   b_data_i           buffer read data, valid the cycle after b_re
//   dat_o, val_o       output word (FIFO head) and its valid
//   rdy_i              consumer ready; a beat transfers on val_o & rdy_i
//   last_o             dat_o is the final word of the request
//
// Build option:
//   COEF_RD_WRAP_EN    addresses wrap 511->0, every request is accepted and
//                      err_o is tied low. When it is undefined, a request with
//                      base_i+len_i > 512 is rejected through err_o.
//
// State table:
//   IDLE  | no request in progress; start_i is accepted
//   READ  | reads still to be issued
//   DRAIN | all reads issued; in-flight/FIFO words still to be delivered

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module coef_buf_rd #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = `PIXEL_WIDTH*8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              b_re,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              val_o,
    input  logic              rdy_i,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = (ADDR_W)'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     rem_q;
    logic                infl_q, infl_last_q;
    logic [1:0]          occ_q;
    logic [DATA_W-1:0]   dat0_q, dat1_q;
    logic                last0_q, last1_q;
    logic                done_q;
    logic                accept, len_zero, range_ok, pop;

    assign accept   = (state_q == IDLE) && start_i;
    assign len_zero = (len_i == '0);
    assign pop      = val_o && rdy_i;

`ifdef COEF_RD_WRAP_EN
    assign range_ok = 1'b1;
    assign err_o    = 1'b0;
`else
    localparam logic [ADDR_W+1:0] LIMIT = (ADDR_W+2)'(1 << ADDR_W);
    logic [ADDR_W+1:0] end_sum;
    logic              err_q;

    assign end_sum  = {2'b00, base_i} + {1'b0, len_i};
    assign range_ok = (end_sum <= LIMIT);
    assign err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !len_zero && !range_ok;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue a read only if the words already buffered or in flight, less the
    // one leaving this cycle, leave room in the 2-entry FIFO.
    always_comb begin
        state_d = state_q;
        b_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !len_zero && range_ok) state_d = READ;
            end
            READ: begin
                if (({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop})) begin
                    b_re = 1'b1;
                    if (rem_q == LEN_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last0_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= 2'd0;
            dat0_q      <= '0;
            dat1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (len_zero) begin
                    done_q <= 1'b1;
                end else if (range_ok) begin
                    addr_q <= base_i;
                    rem_q  <= len_i;
                end
            end
            if (b_re) begin
                addr_q <= addr_q + ADDR_ONE;
                rem_q  <= rem_q - LEN_ONE;
            end
            infl_q      <= b_re;
            infl_last_q <= b_re && (rem_q == LEN_ONE);
            if (pop && last0_q) done_q <= 1'b1;

            // Head-at-entry-0 FIFO so dat_o/last_o come straight from flops.
            case ({infl_q, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        dat0_q  <= b_data_i;
                        last0_q <= infl_last_q;
                    end else begin
                        dat1_q  <= b_data_i;
                        last1_q <= infl_last_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        dat0_q  <= dat1_q;
                        last0_q <= last1_q;
                    end else begin
                        last0_q <= 1'b0;
                    end
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        dat0_q  <= b_data_i;
                        last0_q <= infl_last_q;
                    end else begin
                        dat0_q  <= dat1_q;
                        last0_q <= last1_q;
                        dat1_q  <= b_data_i;
                        last1_q <= infl_last_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign b_addr = addr_q;
    assign dat_o  = dat0_q;
    assign val_o  = (occ_q != 2'd0);
    assign last_o = last0_q;

endmodule

// File: doc/coef_buf_rd.md
# coef_buf_rd

Read-side controller for the 64x512 two-port coefficient buffer. It accepts a block request (base address, word count), issues one-cycle-latency reads on the buffer's B port, and streams the returned 8-pixel words to the downstream consumer (entropy coder / reconstruction) over a valid/ready handshake. A 2-entry skid FIFO absorbs the RAM read latency, so backpressure never loses or duplicates a word. It sits between the coefficient buffer's read port and the consumer.

## Interface
- ADDR_W, 9, buffer address width (512 words)
- DATA_W, `PIXEL_WIDTH*8, buffer word width (from enc_defines.v)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  request pulse; accepted only when busy_o==0
- base_i  in  ADDR_W  first word address, sampled with start_i
- len_i  in  ADDR_W+1  word count 0..512, sampled with start_i
- busy_o  out  1  request in progress
- done_o  out  1  one-cycle pulse, request complete
- err_o  out  1  one-cycle pulse, request rejected (macro-off only)
- b_re  out  1  buffer read enable (active high)
- b_addr  out  ADDR_W  buffer read address
- b_data_i  in  DATA_W  buffer read data, valid the cycle after b_re
- dat_o  out  DATA_W  output word (FIFO head)
- val_o  out  1  dat_o valid
- rdy_i  in  1  consumer ready; beat transfers when val_o&rdy_i
- last_o  out  1  dat_o is the final word of the request

## Operation
- States: IDLE, READ (reads still to issue), DRAIN (all reads issued, FIFO/in-flight non-empty). DRAIN→IDLE on final beat transfer.
- IDLE + start_i + len_i>0 (and range legal): latch base/len, → READ. len_i==0: no reads, done_o pulses next cycle, stays IDLE.
- start_i while busy_o==1: ignored, no side effects.
- Read issue in READ: b_re=1 when (fifo_occ + inflight − pop) < 2, pop = val_o&rdy_i this cycle. b_addr increments by 1 per issued read; remaining count decrements. Last issue → DRAIN.
- Capture: inflight register (1 bit) set on b_re; next cycle b_data_i written into FIFO tail. Never overflows by construction.
- last_o: tag bit stored with each FIFO entry, set on the word read for remaining==1.
- busy_o=1 from the cycle after acceptance until done_o cycle inclusive-of-transition: busy_o is 0 in the done_o cycle, so start_i in that cycle is accepted.
- done_o: pulses the cycle after the beat with last_o transferred.
- Reset (any time): all state cleared, in-flight read data discarded; no done_o.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, b_re=0, b_addr=0, val_o=0, last_o=0, dat_o=0.
- start_i sampled at edge T0; b_re first high in cycle T0+1; b_data_i valid T0+2; val_o first high T0+3.
- With rdy_i held 1: one word per cycle sustained; a len=N request transfers N beats in cycles T0+3..T0+N+2; done_o at T0+N+3.
- rdy_i low: val_o/dat_o/last_o hold; reads stop after at most 2 words buffered; resume the cycle rdy_i returns.
- Outputs dat_o/val_o/last_o are register-driven; rdy_i→b_re is the only combinational path.

## Configuration
- COEF_RD_WRAP_EN defined: b_addr wraps 511→0; any base_i/len_i≤512 accepted; err_o tied 0.
- Undefined: request with base_i+len_i>512 rejected: err_o pulses the cycle after start_i, no reads, no done_o, stays IDLE.

## Test plan
- base=0, len=4, rdy_i=1 -> b_re cycles 1–4 with addr 0..3; beats cycles 3–6, last_o on 4th; done_o cycle 7.
- base=10, len=8, rdy_i toggling 1/0 each cycle -> exactly 8 beats, data order addr 10..17, no duplicates, FIFO occupancy ≤2.
- rdy_i=0 for 20 cycles mid-burst -> b_re stops after 2 outstanding words, val_o/dat_o stable, resumes with no loss.
- base=508, len=8 -> macro on: addresses 508..511,0..3, done_o; macro off: err_o pulse, no b_re.
- len=0 -> done_o next cycle, no b_re, busy_o stays 0; start_i during busy -> ignored.
- rst_n low during READ with one read in flight -> all outputs to reset values immediately; next start behaves normally.
